// File: rtl/ibex_avalon_data_bridge.sv
// ibex_avalon_data_bridge: Ibex data port to Avalon-MM bridge with in-order read/write completions (optional IBEX_DBRIDGE_ERR_EN keeps read response codes)
module ibex_avalon_data_bridge #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_read,
    input  logic        core_write,
    input  logic [31:0] core_addr,
    input  logic [3:0]  core_be,
    input  logic [31:0] core_wdata,
    output logic        core_busy,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_wrespvalid,
    output logic [1:0]  core_resp,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic [1:0]  avm_response
);
    localparam int AW = $clog2(DEPTH);
`ifdef IBEX_DBRIDGE_ERR_EN
    localparam int RW = 34;
`else
    localparam int RW = 32;
`endif
    logic [DEPTH-1:0] ord_q;
    logic [AW-1:0]    ord_wp, ord_rp, rd_wp, rd_rp;
    logic [AW:0]      ord_cnt, rd_cnt, rd_pend;
    logic [RW-1:0]    rd_mem [DEPTH];
    logic [RW-1:0]    rd_in;
    logic             full, rd_acc, wr_acc, accept, ret, head_wr, head_rd, pop_ord;
    assign full           = ord_cnt == (AW+1)'(DEPTH);
    assign avm_read       = core_read & ~full;
    assign avm_write      = core_write & ~full;
    assign core_busy      = avm_waitrequest | full;
    assign avm_address    = core_addr;
    assign avm_byteenable = core_be;
    assign avm_writedata  = core_wdata;
    assign rd_acc         = avm_read & ~avm_waitrequest;
    assign wr_acc         = avm_write & ~avm_waitrequest;
    assign accept         = rd_acc | wr_acc;
    assign ret            = avm_readdatavalid & (rd_pend != '0);
    assign head_wr        = (ord_cnt != '0) & ord_q[ord_rp];
    assign head_rd        = (ord_cnt != '0) & ~ord_q[ord_rp] & (rd_cnt != '0);
    assign pop_ord        = head_wr | head_rd;
    assign core_wrespvalid = head_wr;
    assign core_rvalid     = head_rd;
    assign core_rdata      = head_rd ? rd_mem[rd_rp][31:0] : '0;
`ifdef IBEX_DBRIDGE_ERR_EN
    assign rd_in     = {avm_response, avm_readdata};
    assign core_resp = head_rd ? rd_mem[rd_rp][33:32] : 2'b00;
`else
    logic unused_resp;
    assign unused_resp = ^avm_response;
    assign rd_in       = avm_readdata;
    assign core_resp   = 2'b00;
`endif
    // Order FIFO of transaction types (1 = write) plus outstanding-read and read-FIFO bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ord_q   <= '0;
            ord_wp  <= '0;
            ord_rp  <= '0;
            ord_cnt <= '0;
            rd_wp   <= '0;
            rd_rp   <= '0;
            rd_cnt  <= '0;
            rd_pend <= '0;
        end else begin
            if (accept) begin
                ord_q[ord_wp] <= wr_acc;
                ord_wp        <= ord_wp + AW'(1);
            end
            if (pop_ord) ord_rp <= ord_rp + AW'(1);
            if (ret) rd_wp <= rd_wp + AW'(1);
            if (head_rd) rd_rp <= rd_rp + AW'(1);
            ord_cnt <= ord_cnt + (AW+1)'(accept) - (AW+1)'(pop_ord);
            rd_cnt  <= rd_cnt + (AW+1)'(ret) - (AW+1)'(head_rd);
            rd_pend <= rd_pend + (AW+1)'(rd_acc) - (AW+1)'(ret);
        end
    end
    // Read-data storage; entries are only consumed behind the counters above
    always_ff @(posedge clk_i) begin
        if (ret) rd_mem[rd_wp] <= rd_in;
    end
endmodule

// File: tb/tb_ibex_avalon_data_bridge.sv
// tb_ibex_avalon_data_bridge: vector table, directed corner cases and randomized model check of the data bridge
module tb_ibex_avalon_data_bridge;
    localparam int DEPTH = 4;
    logic        clk_i = 0, rst_ni = 0;
    logic        core_read = 0, core_write = 0;
    logic [31:0] core_addr = 0, core_wdata = 0;
    logic [3:0]  core_be = 0;
    logic        core_busy, core_rvalid, core_wrespvalid;
    logic [31:0] core_rdata, avm_address, avm_writedata;
    logic [1:0]  core_resp;
    logic        avm_read, avm_write;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 0, avm_readdatavalid = 0;
    logic [31:0] avm_readdata = 0;
    logic [1:0]  avm_response = 0;
    int          pass_cnt = 0, chk_cnt = 0;

    ibex_avalon_data_bridge #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_read(core_read), .core_write(core_write), .core_addr(core_addr),
        .core_be(core_be), .core_wdata(core_wdata), .core_busy(core_busy),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .core_wrespvalid(core_wrespvalid), .core_resp(core_resp),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_response(avm_response)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic rd, wr, wt;
        logic e_read, e_write, e_busy;
    } vec_t;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc;
        @(posedge clk_i);
        #1;
    endtask

    task automatic rst_pulse;
        rst_ni = 0;
        core_read = 0;
        core_write = 0;
        avm_waitrequest = 0;
        avm_readdatavalid = 0;
        cyc;
        cyc;
        rst_ni = 1;
    endtask

    function automatic logic [1:0] exp_resp(input logic [1:0] r);
`ifdef IBEX_DBRIDGE_ERR_EN
        return r;
`else
        return 2'b00;
`endif
    endfunction

    initial begin
        vec_t        vecs[6];
        bit          oq[$];
        logic [33:0] rq[$];
        logic [33:0] e;
        int          fab_pend, tr, tw;
        bit          held, acc, exp_w, exp_r, exp_full, rv;
        // request path and reset outputs while held in reset
        vecs[0] = '{0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 0, 1, 0, 0};
        vecs[2] = '{0, 1, 0, 0, 1, 0};
        vecs[3] = '{1, 0, 1, 1, 0, 1};
        vecs[4] = '{0, 1, 1, 0, 1, 1};
        vecs[5] = '{0, 0, 1, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            core_read = vecs[i].rd;
            core_write = vecs[i].wr;
            avm_waitrequest = vecs[i].wt;
            #1;
            chk("vec_req", 34'({avm_read, avm_write, core_busy}),
                34'({vecs[i].e_read, vecs[i].e_write, vecs[i].e_busy}));
            chk("vec_rst_out", 34'({core_rvalid, core_wrespvalid, core_resp, core_rdata}), 34'(0));
            cyc;
        end
        rst_pulse;
        // single write
        core_write = 1; core_addr = 32'h100; core_wdata = 32'h1234_5678; core_be = 4'hF;
        #1;
        chk("sw_acc", 34'({core_busy, avm_write, core_wrespvalid}), 34'(3'b010));
        chk("sw_addr", 34'(avm_address), 34'(32'h100));
        chk("sw_data", 34'(avm_writedata), 34'(32'h1234_5678));
        chk("sw_be", 34'(avm_byteenable), 34'(4'hF));
        cyc;
        core_write = 0;
        #1;
        chk("sw_resp", 34'({core_wrespvalid, core_resp}), 34'(3'b100));
        cyc;
        chk("sw_once", 34'(core_wrespvalid), 34'(0));
        // write after pending read
        rst_pulse;
        tr = -1; tw = -1;
        for (int i = 0; i < 10; i++) begin
            core_read = (i == 0);
            core_addr = (i == 0) ? 32'h200 : 32'h204;
            core_write = (i == 1);
            avm_readdatavalid = (i == 5);
            avm_readdata = 32'hCAFE_F00D;
            #1;
            if (core_rvalid) begin
                tr = i;
                chk("war_rdata", 34'(core_rdata), 34'(32'hCAFE_F00D));
            end
            if (core_wrespvalid) tw = i;
            cyc;
        end
        avm_readdatavalid = 0;
        chk("war_rtime", 34'(tr), 34'(6));
        chk("war_wtime", 34'(tw), 34'(7));
        // full
        rst_pulse;
        core_read = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full_fill", 34'(core_busy), 34'(0));
            cyc;
        end
        #1;
        chk("full_block", 34'({core_busy, avm_read}), 34'(2'b10));
        cyc;
        avm_readdatavalid = 1; avm_readdata = 32'h11;
        #1;
        chk("full_nobypass", 34'(core_rvalid), 34'(0));
        cyc;
        avm_readdatavalid = 0;
        #1;
        chk("full_resp", 34'({core_rvalid, core_rdata}), 34'({1'b1, 32'h11}));
        cyc;
        #1;
        chk("full_accept", 34'({core_busy, avm_read}), 34'(2'b01));
        cyc;
        core_read = 0;
        #1;
        chk("full_again", 34'(core_busy), 34'(1));
        // stall
        rst_pulse;
        core_write = 1; core_addr = 32'hABC0; core_wdata = 32'hDEAD_BEEF; avm_waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_busy", 34'({core_busy, avm_write, core_wrespvalid}), 34'(3'b110));
            chk("stall_addr", 34'(avm_address), 34'(32'hABC0));
            chk("stall_data", 34'(avm_writedata), 34'(32'hDEAD_BEEF));
            cyc;
        end
        avm_waitrequest = 0;
        #1;
        chk("stall_acc", 34'(core_busy), 34'(0));
        cyc;
        core_write = 0;
        #1;
        chk("stall_resp", 34'(core_wrespvalid), 34'(1));
        cyc;
        chk("stall_once", 34'(core_wrespvalid), 34'(0));
        // error response
        rst_pulse;
        core_read = 1;
        cyc;
        core_read = 0; avm_readdatavalid = 1; avm_readdata = 32'h0BAD; avm_response = 2'b10;
        cyc;
        avm_readdatavalid = 0; avm_response = 0;
        #1;
        chk("err_resp", 34'({core_rvalid, core_resp, core_rdata}),
            34'({1'b1, exp_resp(2'b10), 32'h0BAD}));
        // reset mid-operation
        rst_pulse;
        core_read = 1;
        cyc;
        cyc;
        core_read = 0;
        #2 rst_ni = 0;
        #2 rst_ni = 1;
        cyc;
        avm_readdatavalid = 1; avm_readdata = 32'h77;
        cyc;
        #1;
        chk("rst_drop0", 34'(core_rvalid), 34'(0));
        cyc;
        avm_readdatavalid = 0;
        #1;
        chk("rst_drop1", 34'(core_rvalid), 34'(0));
        cyc;
        chk("rst_drop2", 34'(core_rvalid), 34'(0));
        core_read = 1;
        cyc;
        core_read = 0; avm_readdatavalid = 1; avm_readdata = 32'h55AA;
        cyc;
        avm_readdatavalid = 0;
        #1;
        chk("rst_next", 34'({core_rvalid, core_rdata}), 34'({1'b1, 32'h55AA}));
        // randomized traffic against a transaction-order model
        rst_pulse;
        fab_pend = 0;
        held = 0;
        for (int c = 0; c < 3300; c++) begin
            if (!held) begin
                int r;
                r = (c < 3000) ? $urandom_range(0, 2) : 0;
                core_read = (r == 1);
                core_write = (r == 2);
                core_addr = $urandom;
                core_wdata = $urandom;
                core_be = 4'($urandom);
            end
            avm_waitrequest = ($urandom_range(0, 3) == 0);
            rv = (fab_pend > 0) && ($urandom_range(0, 2) != 0);
            avm_readdatavalid = rv;
            avm_readdata = $urandom;
            avm_response = 2'($urandom);
            @(negedge clk_i);
            exp_full = (oq.size() == DEPTH);
            chk("rnd_req", 34'({core_busy, avm_read, avm_write}),
                34'({avm_waitrequest | exp_full, core_read & ~exp_full, core_write & ~exp_full}));
            chk("rnd_addr", 34'(avm_address), 34'(core_addr));
            exp_w = oq.size() > 0 && oq[0];
            exp_r = oq.size() > 0 && !oq[0] && rq.size() > 0;
            chk("rnd_cmpl", 34'({core_wrespvalid, core_rvalid}), 34'({exp_w, exp_r}));
            if (core_rvalid && exp_r) begin
                e = rq.pop_front();
                void'(oq.pop_front());
                chk("rnd_rdata", 34'({core_resp, core_rdata}), {exp_resp(e[33:32]), e[31:0]});
            end
            if (core_wrespvalid && exp_w) begin
                void'(oq.pop_front());
                chk("rnd_wresp", 34'(core_resp), 34'(0));
            end
            if (rv) begin
                rq.push_back({avm_response, avm_readdata});
                fab_pend--;
            end
            acc = (core_read | core_write) & ~exp_full & ~avm_waitrequest;
            held = (core_read | core_write) & ~acc;
            if (acc) begin
                oq.push_back(core_write);
                if (core_read) fab_pend++;
            end
            cyc;
        end
        chk("rnd_drain", 34'(oq.size()), 34'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
